// File: rtl/text_console_writer_if.sv
// Byte-stream input and character-buffer write port of the text console writer.
// The master side feeds bytes and watches the buffer writes; the slave side is the writer.
interface text_console_writer_if #(
  parameter int AW = 12
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          we;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  waddr,
    input  wdata,
    input  we
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output waddr,
    output wdata,
    output we
  );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: turns an ASCII byte stream into writes to a ROWS x COLS
// character buffer, tracking a cursor and handling CR, LF, BS, FF, line wrap
// and screen wrap. Lines and the whole screen are cleared by streaming spaces.
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12,
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  text_console_writer_if.slave   io,
  output logic [CLW-1:0]         cur_col,
  output logic [RW-1:0]          cur_row,
  output logic                   busy
);

  localparam int          TOTAL = ROWS * COLS;
  // One extra bit so the clear counter can reach TOTAL even when TOTAL == 2**AW.
  localparam int          CW    = AW + 1;
  localparam logic [7:0]  SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [CLW-1:0]  col_q,   col_d;
  logic [RW-1:0]   row_q,   row_d;
  logic [AW-1:0]   base_q,  base_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            we_q,    we_d;

  logic            last_col;
  logic            last_row;
  logic [RW-1:0]   nl_row;
  logic [AW-1:0]   nl_base;
  logic [AW-1:0]   cur_addr;
  logic            printable;

  // Cursor-derived helpers: row_base tracks row*COLS by add/wrap, so no multiplier.
  always_comb begin
    last_col  = (col_q == CLW'(COLS - 1));
    last_row  = (row_q == RW'(ROWS - 1));
    nl_row    = last_row ? '0 : row_q + RW'(1);
    nl_base   = last_row ? '0 : base_q + AW'(COLS);
    cur_addr  = base_q + AW'(col_q);
    printable = (io.in_data >= 8'h20) && (io.in_data != 8'h7F);
  end

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          if (printable) begin
            we_d    = 1'b1;
            waddr_d = cur_addr;
            wdata_d = io.in_data;
            if (last_col) begin
              // Wrap: glyph takes this cycle, the new row is cleared from the next one.
              col_d   = '0;
              row_d   = nl_row;
              base_d  = nl_base;
              cnt_d   = '0;
              state_d = CLR_LINE;
            end else begin
              col_d = col_q + CLW'(1);
            end
          end else if (io.in_data == 8'h0D) begin
            col_d = '0;
          end else if (io.in_data == 8'h0A) begin
            // No glyph to write, so the first clear write goes out right away.
            col_d   = '0;
            row_d   = nl_row;
            base_d  = nl_base;
            we_d    = 1'b1;
            waddr_d = nl_base;
            wdata_d = SPACE;
            cnt_d   = CW'(1);
            state_d = CLR_LINE;
          end else if (io.in_data == 8'h08) begin
            if (col_q != '0) begin
              col_d   = col_q - CLW'(1);
              we_d    = 1'b1;
              waddr_d = cur_addr - AW'(1);
              wdata_d = SPACE;
            end
          end else if (io.in_data == 8'h0C) begin
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
            cnt_d   = '0;
            state_d = CLR_ALL;
          end
        end
      end

      CLR_LINE: begin
        if (cnt_q == CW'(COLS)) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = base_q + AW'(cnt_q);
          wdata_d = SPACE;
          cnt_d   = cnt_q + CW'(1);
        end
      end

      CLR_ALL: begin
        if (cnt_q == CW'(TOTAL)) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
          base_d  = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = cnt_q[AW-1:0];
          wdata_d = SPACE;
          cnt_d   = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = CLR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  // State, cursor and registered write-port update; reset restarts a full-screen clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign io.in_ready = (state_q == IDLE);
  assign io.waddr    = waddr_q;
  assign io.wdata    = wdata_q;
  assign io.we       = we_q;
  assign cur_col     = col_q;
  assign cur_row     = row_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Directed testbench for text_console_writer.
module tb_text_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int AW   = 12;

  if (ROWS * COLS > (1 << AW)) begin : g_geom_check
    $error("ROWS*COLS does not fit in AW address bits");
  end

  logic       clk;
  logic       reset;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  text_console_writer_if #(.AW(AW)) bus ();

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .io      (bus.slave),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic check_full_clear(input string pfx);
    for (int k = 0; k < ROWS * COLS; k++) begin
      tick();
      chk({pfx, "_we"},    {31'd0, bus.we},       32'd1);
      chk({pfx, "_waddr"}, {20'd0, bus.waddr},    k);
      chk({pfx, "_wdata"}, {24'd0, bus.wdata},    32'h20);
      chk({pfx, "_rdy"},   {31'd0, bus.in_ready}, 32'd0);
    end
    tick();
    chk({pfx, "_end_we"},  {31'd0, bus.we},       32'd0);
    chk({pfx, "_end_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    chk({pfx, "_end_bsy"}, {31'd0, busy},         32'd0);
    chk({pfx, "_end_col"}, {25'd0, cur_col},      32'd0);
    chk({pfx, "_end_row"}, {27'd0, cur_row},      32'd0);
  endtask

  initial begin
    int lowcnt;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) tick();

    // Reset values.
    chk("rst_we",    {31'd0, bus.we},       32'd0);
    chk("rst_waddr", {20'd0, bus.waddr},    32'd0);
    chk("rst_wdata", {24'd0, bus.wdata},    32'd0);
    chk("rst_rdy",   {31'd0, bus.in_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},         32'd1);
    chk("rst_col",   {25'd0, cur_col},      32'd0);
    chk("rst_row",   {27'd0, cur_row},      32'd0);

    // Boot clear: 2400 ascending space writes.
    reset = 1'b0;
    check_full_clear("boot");

    // 'A','B' back-to-back, CR, LF.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    tick();
    chk("A_we",    {31'd0, bus.we},       32'd1);
    chk("A_waddr", {20'd0, bus.waddr},    32'd0);
    chk("A_wdata", {24'd0, bus.wdata},    32'h41);
    chk("A_rdy",   {31'd0, bus.in_ready}, 32'd1);
    chk("A_col",   {25'd0, cur_col},      32'd1);
    bus.in_data = 8'h42;
    tick();
    chk("B_waddr", {20'd0, bus.waddr},    32'd1);
    chk("B_wdata", {24'd0, bus.wdata},    32'h42);
    chk("B_col",   {25'd0, cur_col},      32'd2);
    bus.in_data = 8'h0D;
    tick();
    chk("CR_we",   {31'd0, bus.we},       32'd0);
    chk("CR_col",  {25'd0, cur_col},      32'd0);
    chk("CR_row",  {27'd0, cur_row},      32'd0);
    bus.in_data = 8'h0A;
    tick();
    bus.in_valid = 1'b0;
    chk("LF_we",    {31'd0, bus.we},       32'd1);
    chk("LF_waddr", {20'd0, bus.waddr},    32'd80);
    chk("LF_wdata", {24'd0, bus.wdata},    32'h20);
    chk("LF_busy",  {31'd0, busy},         32'd1);
    chk("LF_rdy",   {31'd0, bus.in_ready}, 32'd0);
    chk("LF_col",   {25'd0, cur_col},      32'd0);
    chk("LF_row",   {27'd0, cur_row},      32'd1);
    for (int j = 1; j < COLS; j++) begin
      tick();
      chk("LF_clr_we",    {31'd0, bus.we},    32'd1);
      chk("LF_clr_waddr", {20'd0, bus.waddr}, 80 + j);
      chk("LF_clr_rdy",   {31'd0, bus.in_ready}, 32'd0);
    end
    tick();
    chk("LF_end_we",  {31'd0, bus.we},       32'd0);
    chk("LF_end_rdy", {31'd0, bus.in_ready}, 32'd1);

    // Move to row 29, then fill it: wrap clears row 0.
    for (int r = 0; r < 28; r++) begin
      send(8'h0A);
      wait_idle(200);
    end
    chk("r29_row", {27'd0, cur_row}, 32'd29);
    for (int i = 0; i < COLS; i++) begin
      bus.in_data  = 8'h78;
      bus.in_valid = 1'b1;
      tick();
      chk("x_we",    {31'd0, bus.we},    32'd1);
      chk("x_waddr", {20'd0, bus.waddr}, 2320 + i);
      chk("x_wdata", {24'd0, bus.wdata}, 32'h78);
    end
    bus.in_valid = 1'b0;
    chk("wrap_col", {25'd0, cur_col}, 32'd0);
    chk("wrap_row", {27'd0, cur_row}, 32'd0);
    lowcnt = (bus.in_ready === 1'b0) ? 1 : 0;
    for (int j = 0; j < COLS; j++) begin
      tick();
      chk("wrap_clr_we",    {31'd0, bus.we},    32'd1);
      chk("wrap_clr_waddr", {20'd0, bus.waddr}, j);
      chk("wrap_clr_wdata", {24'd0, bus.wdata}, 32'h20);
      if (bus.in_ready === 1'b0) lowcnt++;
    end
    tick();
    chk("wrap_rdy",    {31'd0, bus.in_ready}, 32'd1);
    chk("wrap_lowcnt", lowcnt,                32'd81);

    // Backspace and ignored controls at row 2.
    send(8'h0A);
    wait_idle(200);
    send(8'h0A);
    wait_idle(200);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    chk("bs_pre_col", {25'd0, cur_col}, 32'd5);
    chk("bs_pre_row", {27'd0, cur_row}, 32'd2);
    send(8'h08);
    chk("bs_we",    {31'd0, bus.we},    32'd1);
    chk("bs_waddr", {20'd0, bus.waddr}, 32'd164);
    chk("bs_wdata", {24'd0, bus.wdata}, 32'h20);
    chk("bs_col",   {25'd0, cur_col},   32'd4);
    chk("bs_rdy",   {31'd0, bus.in_ready}, 32'd1);
    send(8'h0D);
    chk("cr2_col", {25'd0, cur_col}, 32'd0);
    send(8'h08);
    chk("bs0_we",  {31'd0, bus.we},    32'd0);
    chk("bs0_col", {25'd0, cur_col},   32'd0);
    chk("bs0_row", {27'd0, cur_row},   32'd2);
    send(8'h07);
    chk("bel_we",  {31'd0, bus.we},       32'd0);
    chk("bel_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("bel_col", {25'd0, cur_col},      32'd0);
    send(8'h7F);
    chk("del_we",  {31'd0, bus.we},       32'd0);
    chk("del_rdy", {31'd0, bus.in_ready}, 32'd1);

    // FF at (10,3) with 'Z' held during the clear.
    send(8'h0A);
    wait_idle(200);
    for (int i = 0; i < 10; i++) send(8'h62);
    chk("ff_pre_col", {25'd0, cur_col}, 32'd10);
    chk("ff_pre_row", {27'd0, cur_row}, 32'd3);
    bus.in_data  = 8'h0C;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 8'h5A;
    chk("ff_we",   {31'd0, bus.we},       32'd0);
    chk("ff_busy", {31'd0, busy},         32'd1);
    chk("ff_rdy",  {31'd0, bus.in_ready}, 32'd0);
    chk("ff_col",  {25'd0, cur_col},      32'd0);
    chk("ff_row",  {27'd0, cur_row},      32'd0);
    for (int k = 0; k < ROWS * COLS; k++) begin
      tick();
      chk("ff_clr_we",    {31'd0, bus.we},    32'd1);
      chk("ff_clr_waddr", {20'd0, bus.waddr}, k);
      chk("ff_clr_wdata", {24'd0, bus.wdata}, 32'h20);
      chk("ff_clr_busy",  {31'd0, busy},      32'd1);
      chk("ff_clr_col",   {25'd0, cur_col},   32'd0);
    end
    tick();
    chk("ff_end_we",   {31'd0, bus.we},       32'd0);
    chk("ff_end_rdy",  {31'd0, bus.in_ready}, 32'd1);
    chk("ff_end_busy", {31'd0, busy},         32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("Z_we",    {31'd0, bus.we},    32'd1);
    chk("Z_waddr", {20'd0, bus.waddr}, 32'd0);
    chk("Z_wdata", {24'd0, bus.wdata}, 32'h5A);
    chk("Z_col",   {25'd0, cur_col},   32'd1);
    chk("Z_row",   {27'd0, cur_row},   32'd0);

    // Reset during line clear at write 40, then full clear restarts.
    send(8'h0A);
    chk("rl_waddr", {20'd0, bus.waddr}, 32'd80);
    for (int j = 1; j <= 40; j++) begin
      tick();
      chk("rl_clr_waddr", {20'd0, bus.waddr}, 80 + j);
    end
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("rl_rst_we",   {31'd0, bus.we},       32'd0);
      chk("rl_rst_rdy",  {31'd0, bus.in_ready}, 32'd0);
      chk("rl_rst_busy", {31'd0, busy},         32'd1);
      chk("rl_rst_col",  {25'd0, cur_col},      32'd0);
      chk("rl_rst_row",  {27'd0, cur_row},      32'd0);
    end
    reset = 1'b0;
    check_full_clear("reclr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream feeder for the display block's character-buffer write port (waddr/wdata/we).
- Consumes an ASCII byte stream, for example from the UART receive path, over a valid/ready handshake.
- Maintains a cursor and writes glyph codes into the ROWS x COLS text buffer, applying terminal control semantics: CR, LF, BS, FF, line wrap and screen wrap.
- Clears lines and the screen autonomously by streaming space characters.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
AW, 12, write address width; ROWS*COLS <= 2**AW is required, and the bench checks it with an elaboration assertion

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  8  byte to display
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a byte this cycle
waddr  output  AW  buffer write address, row*COLS+col
wdata  output  8  glyph code to write
we  output  1  write strobe, one write per cycle asserted
cur_col  output  $clog2(COLS)  cursor column
cur_row  output  $clog2(ROWS)  cursor row
busy  output  1  high in the CLR_LINE and CLR_ALL states

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values while reset is high:
  - state=CLR_ALL with clear counter 0
  - we=0, waddr=0, wdata=0, in_ready=0, busy=1
  - cur_col=0, cur_row=0, row_base=0
- Handshake:
  - in_ready = (state==IDLE), combinational from state.
  - A byte is accepted when in_valid&&in_ready.
  - in_data may change freely when not accepted.
  - Throughput is one byte per cycle in IDLE.
- Outputs:
  - waddr, wdata and we are registered.
  - Latency: a byte accepted at cycle N produces its write at N+1.
  - we=0 on any cycle with no write.
- Address arithmetic:
  - Use a row_base register (row*COLS) maintained by add/subtract of COLS. No multiplier.
  - waddr = row_base + col, truncated to AW bits.
- States: IDLE, CLR_LINE, CLR_ALL.
- CLR_ALL:
  - Writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, in ascending order.
  - The first write is on the cycle after entry.
  - After the last write: state=IDLE, cursor (0,0).
  - Default CLR_ALL = 2400 write cycles.
- CLR_LINE:
  - Writes 0x20 to row_base+0..row_base+COLS-1 of the (new) current row; COLS cycles.
  - Then returns to IDLE.
- Byte decode in IDLE:
  - 0x20-0x7E and 0x80-0xFF (printable):
    - Write in_data at the cursor; col+1.
    - If col was COLS-1: col=0 and perform newline.
  - 0x0D CR: col=0; no write.
  - 0x0A LF: col=0 and perform newline.
  - 0x08 BS:
    - If col>0: col-1 and write 0x20 at the new position.
    - If col==0: no-op (no row back-step).
  - 0x0C FF: enter CLR_ALL; the cursor holds at (0,0) throughout.
  - All other 0x00-0x1F and 0x7F: ignored, no write; the byte is still consumed.
- Newline:
  - row+1, or row=0 if row==ROWS-1 (screen wrap, no scroll).
  - row_base updated in the same cycle; enter CLR_LINE for the new row.
- Printable at the last column:
  - Glyph write at N+1.
  - Clear writes at N+2..N+COLS+1.
  - in_ready low N+1..N+COLS+1; high at N+COLS+2.
- LF accepted at N: clear writes at N+1..N+COLS; in_ready high at N+COLS+1.
- Reset asserted mid-clear or mid-write:
  - Aborts immediately; no further we pulses during reset.
  - A full CLR_ALL restarts from address 0 after release.
- Byte presented while busy: not consumed; it must be held by the producer and is accepted on the first IDLE cycle.
- cur_col/cur_row reflect the post-update cursor from the cycle after acceptance.

Test Plan:
- Reset released at cycle 0 -> we high cycles 1..2400, waddr 0..2399 ascending, wdata=0x20 each; in_ready rises at cycle 2401; cursor (0,0).
- Bytes 'A','B' back-to-back in consecutive cycles, then CR, LF -> two writes:
  - (addr 0, 0x41) then (addr 1, 0x42)
  - CR produces no write
  - LF gives 80 writes of 0x20 to addr 80..159
  - cursor ends (0,1)
- 80 printable 'x' on row 29 -> writes to addr 2320..2399, then 80 clears of addr 0..79; cursor (0,0); in_ready low exactly 81 cycles after the 80th accept.
- At cursor (5,2): BS -> write 0x20 at addr 164, cursor (4,2). At cursor (0,2): BS -> no write, cursor unchanged. Byte 0x07 -> no write, consumed in one cycle.
- FF at cursor (10,3) -> 2400 clear writes, cursor (0,0), busy high throughout; in_valid held with 'Z' during clear -> 'Z' written to addr 0 one cycle after in_ready returns.
- Reset asserted during CLR_LINE write 40 -> no we during reset; after release a full 2400-write clear restarts at addr 0.
